// File: rtl/irq_controller_pkg.sv
// Shared register offsets, register-select type and address decode for irq_controller.
package irq_controller_pkg;

  localparam int unsigned IRQ_PENDING_OFS = 0;
  localparam int unsigned IRQ_MASK_OFS    = 4;
  localparam int unsigned IRQ_EDGE_OFS    = 8;

  typedef enum logic [1:0] {
    RegPending,
    RegMask,
    RegEdge,
    RegNone
  } irq_reg_e;

  // Word addresses only; byte lanes inside a register are not distinguished.
  function automatic irq_reg_e irq_decode(input logic [29:0] adr_word,
                                          input logic [29:0] base_word);
    logic [29:0] ofs;
    ofs = adr_word - base_word;
    if (ofs == 30'(IRQ_PENDING_OFS / 4)) return RegPending;
    if (ofs == 30'(IRQ_MASK_OFS / 4)) return RegMask;
    if (ofs == 30'(IRQ_EDGE_OFS / 4)) return RegEdge;
    return RegNone;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-line synchroniser: SYNC_STAGES flops, asynchronous active-low reset.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic ph1,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: synchronise, detect edge/level, latch pending, mask,
// and drive registered requests into the core.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned NIRQ        = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            memwrite,
  input  logic [31:0]     dataadr,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic [NIRQ-1:0] interrupts,
  output logic            irq_any
);

  logic [NIRQ-1:0] s;
  logic [NIRQ-1:0] prev_q;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] mask_q;
  logic [NIRQ-1:0] edge_q;
  logic [NIRQ-1:0] w1c;
  logic [NIRQ-1:0] rise;
  irq_reg_e        sel;
  logic            unused_bits;

  for (genvar i = 0; i < NIRQ; i++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .ph1  (ph1),
      .reset(reset),
      .d    (irq_in[i]),
      .q    (s[i])
    );
  end

  assign sel         = irq_decode(dataadr[31:2], BASE_ADDR[31:2]);
  assign unused_bits = ^{dataadr[1:0], writedata};

  // A new edge beats a same-cycle W1C; level lines simply mirror the synced input.
  always_comb begin
    w1c       = (memwrite && sel == RegPending) ? writedata[NIRQ-1:0] : '0;
    rise      = s & ~prev_q;
    pending_d = (edge_q & (rise | (pending_q & ~w1c))) | (~edge_q & s);
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      interrupts <= '0;
      irq_any    <= 1'b0;
    end else begin
      prev_q     <= s;
      pending_q  <= pending_d;
      if (memwrite && sel == RegMask) mask_q <= writedata[NIRQ-1:0];
      if (memwrite && sel == RegEdge) edge_q <= writedata[NIRQ-1:0];
      interrupts <= pending_q & mask_q;
      irq_any    <= |(pending_q & mask_q);
    end
  end

  always_comb begin
    readdata = '0;
    case (sel)
      RegPending: readdata[NIRQ-1:0] = pending_q;
      RegMask:    readdata[NIRQ-1:0] = mask_q;
      RegEdge:    readdata[NIRQ-1:0] = edge_q;
      default:    readdata = '0;
    endcase
  end

endmodule
